// File: rtl/branch_resolve.sv
// branch_resolve: resolution end of the static next-PC prediction made at fetch.
// Each fetched (pc, predicted next pc) pair is held in an in-order FIFO. When EX
// resolves the oldest instruction, the pair is popped and its prediction is
// compared with the actual next PC. A mismatch raises a one-cycle redirect,
// empties the FIFO and holds flush for FLUSH_CYCLES cycles.
// Optional build macro BRANCH_RESOLVE_PERF_EN adds resolve/mispredict counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal operation: predictions pushed, resolutions popped
// ST_FLUSH | squash window after a mispredict; no push, ex_valid ignored
module branch_resolve #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              if_pre_pc,
  output logic                     if_ready,
  input  logic                     ex_valid,
  input  logic [31:0]              ex_next_pc,
  output logic                     redirect,
  output logic [31:0]              redirect_pc,
  output logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef BRANCH_RESOLVE_PERF_EN
  ,
  output logic [31:0]              resolve_cnt,
  output logic [31:0]              mispred_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic [CW-1:0]   sq_cnt_q;
  logic            redirect_q;
  logic [31:0]     redirect_pc_q;
  logic            flush_q;

  logic [31:0]     pc_mem  [DEPTH];
  logic [31:0]     pre_mem [DEPTH];

  logic            push_ok;
  logic            pop_ok;
  logic            mispred;
  logic [31:0]     rd_pre;

  assign rd_pre   = pre_mem[rd_ptr_q];
  assign if_ready = (state_q == ST_RUN) && (occ_q != OCC_FULL);
  assign pop_ok   = (state_q == ST_RUN) && ex_valid && (occ_q != '0);
  assign mispred  = pop_ok && (rd_pre != ex_next_pc);
  // a push in the mispredict cycle belongs to the wrong path, so drop it
  assign push_ok  = if_valid && if_ready && !mispred;

  // next pointer/occupancy values for the normal (non-mispredict) case
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_ok && !pop_ok) begin
      occ_d = occ_q + OCC_ONE;
    end else if (pop_ok && !push_ok) begin
      occ_d = occ_q - OCC_ONE;
    end
  end

  // prediction storage; contents are only meaningful below occupancy, so no reset
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      pc_mem[wr_ptr_q]  <= if_pc;
      pre_mem[wr_ptr_q] <= if_pre_pc;
    end
  end

  // control FSM with registered redirect/flush outputs and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      sq_cnt_q      <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mispred) begin
            state_q       <= ST_FLUSH;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            sq_cnt_q      <= CNT_LOAD;
            redirect_q    <= 1'b1;
            redirect_pc_q <= ex_next_pc;
            flush_q       <= 1'b1;
          end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
          end
        end
        ST_FLUSH: begin
          redirect_q <= 1'b0;
          if (sq_cnt_q == '0) begin
            state_q <= ST_RUN;
            flush_q <= 1'b0;
          end else begin
            sq_cnt_q <= sq_cnt_q - CNT_ONE;
            flush_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign flush       = flush_q;
  assign occupancy   = occ_q;

`ifdef BRANCH_RESOLVE_PERF_EN
  logic [31:0] resolve_cnt_q;
  logic [31:0] mispred_cnt_q;

  // resolution statistics; they survive flushes and only clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      resolve_cnt_q <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (pop_ok) begin
        resolve_cnt_q <= resolve_cnt_q + 32'd1;
      end
      if (mispred) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign resolve_cnt = resolve_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed steps followed by random traffic, every cycle
// checked against a queue-based model of the prediction FIFO.
module tb_branch_resolve;

  localparam int DEPTH = 4;
  localparam int FC    = 2;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_pre_pc;
  logic          if_ready;
  logic          ex_valid;
  logic [31:0]   ex_next_pc;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          flush;
  logic [OW-1:0] occupancy;
`ifdef BRANCH_RESOLVE_PERF_EN
  logic [31:0]   resolve_cnt;
  logic [31:0]   mispred_cnt;
`endif

  branch_resolve #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_pre_pc(if_pre_pc), .if_ready(if_ready),
    .ex_valid(ex_valid), .ex_next_pc(ex_next_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .occupancy(occupancy)
`ifdef BRANCH_RESOLVE_PERF_EN
    , .resolve_cnt(resolve_cnt), .mispred_cnt(mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pre;
  } ent_t;

  ent_t        m_q[$];
  int          m_flush_left = 0;
  logic        m_redirect   = 1'b0;
  logic [31:0] m_rpc        = '0;
  logic [31:0] m_res        = '0;
  logic [31:0] m_mis        = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: drive at negedge, check ready, advance model, check outputs after edge
  task automatic step(input logic r, input logic iv, input logic [31:0] pc,
                      input logic [31:0] pre, input logic ev, input logic [31:0] nx);
    logic ready;
    ent_t e;
    rst = r; if_valid = iv; if_pc = pc; if_pre_pc = pre; ex_valid = ev; ex_next_pc = nx;
    #1;
    ready = (m_flush_left == 0) && (m_q.size() < DEPTH);
    chk("if_ready", {31'd0, if_ready}, {31'd0, ready});
    m_redirect = 1'b0;
    if (r) begin
      m_q.delete();
      m_flush_left = 0;
      m_rpc = '0;
      m_res = '0;
      m_mis = '0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else begin
      if (ev && m_q.size() > 0) begin
        e = m_q.pop_front();
        m_res++;
        if (e.pre != nx) begin
          m_mis++;
          m_q.delete();
          m_flush_left = FC;
          m_redirect = 1'b1;
          m_rpc = nx;
        end else if (iv && ready) begin
          m_q.push_back('{pc, pre});
        end
      end else if (iv && ready) begin
        m_q.push_back('{pc, pre});
      end
    end
    @(posedge clk);
    #1;
    chk("redirect", {31'd0, redirect}, {31'd0, m_redirect});
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("flush", {31'd0, flush}, {31'd0, (m_flush_left > 0)});
    chk("occupancy", 32'(occupancy), 32'(m_q.size()));
`ifdef BRANCH_RESOLVE_PERF_EN
    chk("resolve_cnt", resolve_cnt, m_res);
    chk("mispred_cnt", mispred_cnt, m_mis);
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] nx;
    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_pre_pc = '0; ex_valid = 1'b0; ex_next_pc = '0;
    @(negedge clk);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // correct prediction
    step(1'b0, 1'b1, 32'h100, 32'h104, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h104);
    idle();

    // backward branch predicted taken, actually falls through
    step(1'b0, 1'b1, 32'h200, 32'h1F0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h204);
    idle(); idle(); idle();

    // fill to DEPTH, then push+pop on full: only the pop happens
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 32'h300 + 32'(i*4), 32'h304 + 32'(i*4), 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h400, 32'h404, 1'b1, 32'h304);
    idle();
    while (m_q.size() > 0) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, m_q[0].pre);

    // mispredict with 3 in flight; ex_valid during flush ignored; push right after
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h500 + 32'(i*4), 32'h504 + 32'(i*4), 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h600, 32'h604, 1'b1, 32'h900);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hA00);
    step(1'b0, 1'b1, 32'h610, 32'h614, 1'b1, 32'hB00);
    step(1'b0, 1'b1, 32'h900, 32'h904, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h904);

    // pointer wrap with matching predictions
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'h1000 + 32'(i*4), 32'h1004 + 32'(i*4), 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1004 + 32'(i*4));
    end

    // reset in the second flush cycle
    step(1'b0, 1'b1, 32'h700, 32'h800, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h704);
    idle();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    idle();

    // random traffic
    pc = 32'h2000;
    for (int i = 0; i < 400; i++) begin
      nx = $urandom;
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0) nx = m_q[0].pre;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), pc,
           ($urandom_range(0, 1) == 1) ? pc + 32'd4 : $urandom,
           ($urandom_range(0, 1) == 1), nx);
      pc = pc + 32'd4;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Resolution end of the static next-PC prediction made at fetch.
- Buffers each fetched (pc, predicted next pc) pair in an in-order FIFO.
- When EX resolves the same instruction, the block pops the pair and compares the predicted next PC with the actual next PC.
- On a mismatch it issues a one-cycle redirect to fetch, flushes all in-flight predictions, and holds a fetch-squash window.

Parameters:
- DEPTH, 4, number of in-flight predictions; power of 2, ≥2.
- FLUSH_CYCLES, 2, cycles the flush output stays high after a mispredict; ≥1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- if_valid  input  1  fetch issues an instruction with a prediction this cycle
- if_pc  input  32  PC of the fetched instruction
- if_pre_pc  input  32  predicted next PC for that instruction
- if_ready  output  1  block can accept a prediction; combinational
- ex_valid  input  1  EX resolves the oldest in-flight instruction this cycle
- ex_next_pc  input  32  actual next PC (branch/jump target, or pc+4)
- redirect  output  1  one-cycle pulse: fetch must restart at redirect_pc
- redirect_pc  output  32  corrected fetch address
- flush  output  1  squash younger pipeline contents
- occupancy  output  $clog2(DEPTH)+1  number of valid FIFO entries

Behaviour:
- One clock. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: FIFO empty, read/write pointers 0, occupancy 0, state RUN, redirect 0, redirect_pc 0, flush 0, squash counter 0.
- Reset asserted mid-flush returns the block to RUN with an empty FIFO on the next edge.
- States: RUN and FLUSH.
- if_ready = (state==RUN) && (occupancy != DEPTH).
- Push: if_valid && if_ready writes {if_pc, if_pre_pc} at the write pointer; the write pointer increments modulo DEPTH.
- Pop: state==RUN && ex_valid && occupancy != 0 reads the entry at the read pointer; the read pointer increments modulo DEPTH.
- ex_valid while the FIFO is empty, or while in FLUSH, is ignored: no state change, no redirect.
- Push and pop in the same cycle: both occur and occupancy is unchanged. A full FIFO never pushes, even when a pop occurs that cycle, because if_ready is computed from current occupancy.
- Compare: a popped entry whose stored pre_pc equals ex_next_pc (full 32-bit compare) is a correct prediction; nothing further happens.
- Mispredict: a popped entry whose stored pre_pc differs from ex_next_pc triggers the following on the next edge:
  - redirect=1 and redirect_pc=ex_next_pc;
  - flush=1;
  - both pointers and occupancy are cleared to 0; any push in the same cycle is discarded;
  - state moves to FLUSH and the squash counter loads FLUSH_CYCLES-1.
- In FLUSH:
  - redirect is high only for the first cycle; redirect_pc holds its value until the next mispredict.
  - flush stays high for exactly FLUSH_CYCLES cycles. The counter decrements each cycle; when it is 0 the next edge returns to RUN and flush=0.
- Latency: a mispredict is visible on redirect one cycle after the ex_valid cycle. The earliest new push occurs FLUSH_CYCLES cycles after redirect rises.
- No arithmetic beyond the pointer and counter increments; pointers wrap naturally at DEPTH.

Optional Feature:
- Macro: BRANCH_RESOLVE_PERF_EN.
- With the macro defined, two extra output ports are added:
  - resolve_cnt (32): increments on every pop;
  - mispred_cnt (32): increments on every mispredict pop.
  - Both reset to 0, wrap at 2^32, and are not cleared by flush.
- Without the macro, the ports and counters do not exist and all other behaviour is identical.

Test Plan:
1. Reset, then push pc=0x100/pre=0x104; EX ex_next_pc=0x104 -> no redirect, flush stays 0, occupancy returns 0.
2. Push pc=0x200/pre=0x1F0 (backward branch predicted taken); EX ex_next_pc=0x204 -> next cycle redirect=1 for 1 cycle, redirect_pc=0x204, flush=1 for 2 cycles, if_ready=0 during flush, occupancy=0.
3. Push 4 entries without resolving -> occupancy=4 and if_ready=0. Then assert if_valid and ex_valid (match) in the same cycle -> pop only, occupancy=3, if_ready=1 the following cycle.
4. With 3 entries in flight, mispredict on the oldest -> remaining 2 entries discarded. ex_valid pulses during FLUSH are ignored (no second redirect). A push in the cycle after flush drops is accepted.
5. Pointer wrap: 10 push/pop pairs with matching predictions at DEPTH=4 -> every compare correct, no redirect, pointers wrap cleanly.
6. Assert rst during the second flush cycle -> next cycle flush=0, redirect=0, if_ready=1, occupancy=0. With BRANCH_RESOLVE_PERF_EN, counters read 0 after the reset.
